ex_stage: RTL and testbench

Execute stage of the 5-stage core, sitting directly downstream of `id_stage` and upstream of the memory stage. Consumes the decoded `core::pipeline_bus_t` from ID and computes ALU results, branch/jump outcomes and redirect targets. Holds one instruction in a registered EX/MEM output with valid/ready backpressure. An optional iterative RV32M multiplier occupies the stage for multiple cycles.

---
 rtl/ex_stage.sv | 332 +++++++++++++++++++++++++++++++++
 tb/tb_ex_stage.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage core.
//
// Takes the decoded instruction bus from ID, computes the ALU, branch and jump results
// and holds one instruction in a registered EX/MEM output with valid/ready backpressure.
//
// Optional feature: define EX_MUL_EN to build the iterative radix-2 RV32M multiplier.
// Without it, an is_mul instruction completes in one cycle flagged illegal.
//
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   id_bus_i, id_valid_i   decoded instruction and its valid from ID
//   ex_ready_o             EX accepts this cycle
//   flush_i                kill output register contents and any in-flight multiply
//   mem_ready_i            downstream consumes the output register
//   ex_valid_o             output register holds a valid instruction
//   result_o, store_data_o ALU/link/multiply result, registered rs2_data
//   rd_o, rd_wen_o, pc_o   destination, write enable, PC of the held instruction
//   redirect_o, redirect_pc_o  taken branch/jump and its target
//   illegal_o              unsupported operation in the output register

package core;
   localparam int unsigned DATA_WIDTH = 32;

   typedef enum logic [3:0] {
      AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd, AluPassB
   } alu_op_e;

   typedef enum logic [2:0] {BrNone, BrEq, BrNe, BrLt, BrGe, BrLtu, BrGeu} br_op_e;

   typedef enum logic [1:0] {MulLo, MulH, MulHsu, MulHu} mul_op_e;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] pc;
      logic [DATA_WIDTH-1:0] rs1_data;
      logic [DATA_WIDTH-1:0] rs2_data;
      logic [DATA_WIDTH-1:0] imm;
      logic [4:0]            rd;
      logic                  rd_wen;
      alu_op_e               alu_op;
      logic                  op_a_pc;
      logic                  op_b_imm;
      br_op_e                br_op;
      logic                  is_jal;
      logic                  is_jalr;
      logic                  is_mul;
      mul_op_e               mul_op;
   } pipeline_bus_t;
endpackage

module ex_stage
   import core::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  pipeline_bus_t         id_bus_i,
   input  logic                  id_valid_i,
   output logic                  ex_ready_o,
   input  logic                  flush_i,
   input  logic                  mem_ready_i,
   output logic                  ex_valid_o,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic [DATA_WIDTH-1:0] store_data_o,
   output logic [4:0]            rd_o,
   output logic                  rd_wen_o,
   output logic [DATA_WIDTH-1:0] pc_o,
   output logic                  redirect_o,
   output logic [DATA_WIDTH-1:0] redirect_pc_o,
   output logic                  illegal_o
);

   logic [31:0] op_a, op_b, alu_res, target;
   logic        alu_illegal, br_illegal, br_taken;
   logic [31:0] ins_result;
   logic        ins_rd_wen, ins_redirect, ins_illegal;
   logic        out_free, accept, start_mul, load_ins, load_mul, mul_idle, mul_done;
   logic [31:0] mul_res, mul_pc, mul_store;
   logic [4:0]  mul_rd;
   logic        mul_rd_wen;

   logic        valid_q, valid_d, redirect_q, redirect_d, illegal_q, illegal_d;
   logic        rd_wen_q, rd_wen_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] result_q, result_d, store_q, store_d, pc_q, pc_d, rpc_q, rpc_d;

   // Single-cycle datapath
   always_comb begin
      op_a        = id_bus_i.op_a_pc ? id_bus_i.pc : id_bus_i.rs1_data;
      op_b        = id_bus_i.op_b_imm ? id_bus_i.imm : id_bus_i.rs2_data;
      alu_illegal = 1'b0;
      case (id_bus_i.alu_op)
         AluAdd:   alu_res = op_a + op_b;
         AluSub:   alu_res = op_a - op_b;
         AluSll:   alu_res = op_a << op_b[4:0];
         AluSlt:   alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
         AluSltu:  alu_res = {31'b0, op_a < op_b};
         AluXor:   alu_res = op_a ^ op_b;
         AluSrl:   alu_res = op_a >> op_b[4:0];
         AluSra:   alu_res = $signed(op_a) >>> op_b[4:0];
         AluOr:    alu_res = op_a | op_b;
         AluAnd:   alu_res = op_a & op_b;
         AluPassB: alu_res = op_b;
         default: begin
            alu_res     = '0;
            alu_illegal = 1'b1;
         end
      endcase

      br_illegal = 1'b0;
      case (id_bus_i.br_op)
         BrNone: br_taken = 1'b0;
         BrEq:   br_taken = id_bus_i.rs1_data == id_bus_i.rs2_data;
         BrNe:   br_taken = id_bus_i.rs1_data != id_bus_i.rs2_data;
         BrLt:   br_taken = $signed(id_bus_i.rs1_data) < $signed(id_bus_i.rs2_data);
         BrGe:   br_taken = $signed(id_bus_i.rs1_data) >= $signed(id_bus_i.rs2_data);
         BrLtu:  br_taken = id_bus_i.rs1_data < id_bus_i.rs2_data;
         BrGeu:  br_taken = id_bus_i.rs1_data >= id_bus_i.rs2_data;
         default: begin
            br_taken   = 1'b0;
            br_illegal = 1'b1;
         end
      endcase

      target = id_bus_i.is_jalr ? ((id_bus_i.rs1_data + id_bus_i.imm) & ~32'd1)
                                : id_bus_i.pc + id_bus_i.imm;

      ins_result   = alu_res;
      ins_rd_wen   = id_bus_i.rd_wen;
      ins_redirect = br_taken;
      ins_illegal  = 1'b0;
      // With the multiplier built in, is_mul never takes the single-cycle load path
      if (id_bus_i.is_mul || (!id_bus_i.is_jal && !id_bus_i.is_jalr &&
                              (alu_illegal || br_illegal))) begin
         ins_result   = '0;
         ins_rd_wen   = 1'b0;
         ins_redirect = 1'b0;
         ins_illegal  = 1'b1;
      end else if (id_bus_i.is_jal || id_bus_i.is_jalr) begin
         ins_result   = id_bus_i.pc + 32'd4;
         ins_redirect = 1'b1;
      end
   end

   assign out_free   = !valid_q || mem_ready_i;
   assign ex_ready_o = mul_idle && out_free;
   // The instruction behind a draining redirect is wrong-path: swallow it without capture
   assign accept     = id_valid_i && ex_ready_o && !(redirect_q && mem_ready_i);
   assign load_ins   = accept && !start_mul;
   assign load_mul   = mul_done && out_free;

`ifdef EX_MUL_EN
   typedef enum logic [1:0] {StIdle, StBusy, StDone} mul_state_e;

   mul_state_e  state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [63:0] prod_q, prod_d, prod_fix;
   logic [31:0] mcand_q, mcand_d, m_pc_q, m_pc_d, m_store_q, m_store_d;
   logic [4:0]  m_rd_q, m_rd_d;
   logic        m_rd_wen_q, m_rd_wen_d, neg_q, neg_d, hi_q, hi_d, sign_a, sign_b;
   logic [32:0] add_sum;

   assign start_mul = accept && id_bus_i.is_mul;
   assign mul_idle  = state_q == StIdle;
   assign mul_done  = state_q == StDone;

   // prod_q holds {partial high, remaining multiplier bits}; one bit retires per cycle
   assign add_sum  = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
   assign prod_fix = neg_q ? -prod_q : prod_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      prod_d     = prod_q;
      mcand_d    = mcand_q;
      neg_d      = neg_q;
      hi_d       = hi_q;
      m_pc_d     = m_pc_q;
      m_store_d  = m_store_q;
      m_rd_d     = m_rd_q;
      m_rd_wen_d = m_rd_wen_q;
      sign_a     = (id_bus_i.mul_op == MulH || id_bus_i.mul_op == MulHsu) &&
                   id_bus_i.rs1_data[31];
      sign_b     = (id_bus_i.mul_op == MulH) && id_bus_i.rs2_data[31];
      unique case (state_q)
         StIdle: begin
            if (start_mul) begin
               state_d    = StBusy;
               cnt_d      = '0;
               mcand_d    = sign_a ? -id_bus_i.rs1_data : id_bus_i.rs1_data;
               prod_d     = {32'b0, sign_b ? -id_bus_i.rs2_data : id_bus_i.rs2_data};
               neg_d      = sign_a ^ sign_b;
               hi_d       = id_bus_i.mul_op != MulLo;
               m_pc_d     = id_bus_i.pc;
               m_store_d  = id_bus_i.rs2_data;
               m_rd_d     = id_bus_i.rd;
               m_rd_wen_d = id_bus_i.rd_wen;
            end
         end
         StBusy: begin
            prod_d = {add_sum, prod_q[31:1]};
            cnt_d  = cnt_q + 6'd1;
            if (cnt_q == 6'd31) state_d = StDone;
         end
         StDone: begin
            if (out_free) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (flush_i) state_d = StIdle;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         prod_q     <= '0;
         mcand_q    <= '0;
         neg_q      <= 1'b0;
         hi_q       <= 1'b0;
         m_pc_q     <= '0;
         m_store_q  <= '0;
         m_rd_q     <= '0;
         m_rd_wen_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         prod_q     <= prod_d;
         mcand_q    <= mcand_d;
         neg_q      <= neg_d;
         hi_q       <= hi_d;
         m_pc_q     <= m_pc_d;
         m_store_q  <= m_store_d;
         m_rd_q     <= m_rd_d;
         m_rd_wen_q <= m_rd_wen_d;
      end
   end

   assign mul_res    = hi_q ? prod_fix[63:32] : prod_fix[31:0];
   assign mul_pc     = m_pc_q;
   assign mul_store  = m_store_q;
   assign mul_rd     = m_rd_q;
   assign mul_rd_wen = m_rd_wen_q;
`else
   logic unused_mul_op;

   assign unused_mul_op = ^id_bus_i.mul_op;
   assign start_mul     = 1'b0;
   assign mul_idle      = 1'b1;
   assign mul_done      = 1'b0;
   assign mul_res       = '0;
   assign mul_pc        = '0;
   assign mul_store     = '0;
   assign mul_rd        = '0;
   assign mul_rd_wen    = 1'b0;
`endif

   // Output register; flush wins over any load
   always_comb begin
      valid_d    = valid_q;
      redirect_d = redirect_q;
      illegal_d  = illegal_q;
      result_d   = result_q;
      store_d    = store_q;
      rd_d       = rd_q;
      rd_wen_d   = rd_wen_q;
      pc_d       = pc_q;
      rpc_d      = rpc_q;
      if (flush_i) begin
         valid_d    = 1'b0;
         redirect_d = 1'b0;
         illegal_d  = 1'b0;
      end else if (load_mul) begin
         valid_d    = 1'b1;
         redirect_d = 1'b0;
         illegal_d  = 1'b0;
         result_d   = mul_res;
         store_d    = mul_store;
         rd_d       = mul_rd;
         rd_wen_d   = mul_rd_wen;
         pc_d       = mul_pc;
         rpc_d      = '0;
      end else if (load_ins) begin
         valid_d    = 1'b1;
         redirect_d = ins_redirect;
         illegal_d  = ins_illegal;
         result_d   = ins_result;
         store_d    = id_bus_i.rs2_data;
         rd_d       = id_bus_i.rd;
         rd_wen_d   = ins_rd_wen;
         pc_d       = id_bus_i.pc;
         rpc_d      = target;
      end else if (valid_q && mem_ready_i) begin
         valid_d    = 1'b0;
         redirect_d = 1'b0;
         illegal_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q    <= 1'b0;
         redirect_q <= 1'b0;
         illegal_q  <= 1'b0;
         result_q   <= '0;
         store_q    <= '0;
         rd_q       <= '0;
         rd_wen_q   <= 1'b0;
         pc_q       <= '0;
         rpc_q      <= '0;
      end else begin
         valid_q    <= valid_d;
         redirect_q <= redirect_d;
         illegal_q  <= illegal_d;
         result_q   <= result_d;
         store_q    <= store_d;
         rd_q       <= rd_d;
         rd_wen_q   <= rd_wen_d;
         pc_q       <= pc_d;
         rpc_q      <= rpc_d;
      end
   end

   assign ex_valid_o    = valid_q;
   assign redirect_o    = redirect_q;
   assign illegal_o     = illegal_q;
   assign result_o      = result_q;
   assign store_data_o  = store_q;
   assign rd_o          = rd_q;
   assign rd_wen_o      = rd_wen_q;
   assign pc_o          = pc_q;
   assign redirect_pc_o = rpc_q;

endmodule

// File: tb/tb_ex_stage.sv
`timescale 1ns/1ps
module tb_ex_stage;
   import core::*;

`ifdef EX_MUL_EN
   localparam bit MulEn = 1'b1;
`else
   localparam bit MulEn = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   pipeline_bus_t id_bus;
   logic          id_valid, flush, mem_ready;
   logic          ex_ready, ex_valid, rd_wen, redirect, illegal;
   logic [31:0]   result, store_data, pc, redirect_pc;
   logic [4:0]    rd;

   always #5 clk = ~clk;

   ex_stage dut (
      .clk          (clk),
      .rst          (rst),
      .id_bus_i     (id_bus),
      .id_valid_i   (id_valid),
      .ex_ready_o   (ex_ready),
      .flush_i      (flush),
      .mem_ready_i  (mem_ready),
      .ex_valid_o   (ex_valid),
      .result_o     (result),
      .store_data_o (store_data),
      .rd_o         (rd),
      .rd_wen_o     (rd_wen),
      .pc_o         (pc),
      .redirect_o   (redirect),
      .redirect_pc_o(redirect_pc),
      .illegal_o    (illegal)
   );

   typedef struct {
      logic [31:0] result, store_data, pc, redirect_pc;
      logic [4:0]  rd;
      logic        rd_wen, redirect, illegal;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   failures = 0;

   // Abstract model state: output occupancy and remaining multiply time
   logic m_valid = 1'b0, m_redirect = 1'b0, mul_active = 1'b0;
   int   mul_wait = 0;
   exp_t mul_item;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t predict(input pipeline_bus_t b);
      exp_t        e;
      logic [31:0] a, bb, r;
      logic [63:0] sa, sb, p;
      logic        legal, taken;
      e.store_data  = b.rs2_data;
      e.pc          = b.pc;
      e.rd          = b.rd;
      e.rd_wen      = b.rd_wen;
      e.redirect    = 1'b0;
      e.illegal     = 1'b0;
      e.result      = 32'd0;
      e.redirect_pc = b.is_jalr ? ((b.rs1_data + b.imm) & 32'hFFFF_FFFE) : b.pc + b.imm;
      a  = b.op_a_pc ? b.pc : b.rs1_data;
      bb = b.op_b_imm ? b.imm : b.rs2_data;
      if (b.is_mul) begin
         if (MulEn) begin
            sa = (b.mul_op == MulH || b.mul_op == MulHsu) ?
                 {{32{b.rs1_data[31]}}, b.rs1_data} : {32'd0, b.rs1_data};
            sb = (b.mul_op == MulH) ? {{32{b.rs2_data[31]}}, b.rs2_data} : {32'd0, b.rs2_data};
            p  = sa * sb;
            e.result = (b.mul_op == MulLo) ? p[31:0] : p[63:32];
         end else begin
            e.illegal = 1'b1;
            e.rd_wen  = 1'b0;
         end
      end else if (b.is_jal || b.is_jalr) begin
         e.result   = b.pc + 32'd4;
         e.redirect = 1'b1;
      end else begin
         legal = 1'b1;
         r     = 32'd0;
         case (b.alu_op)
            AluAdd:   r = a + bb;
            AluSub:   r = a - bb;
            AluSll:   r = a << bb[4:0];
            AluSlt:   r = ($signed(a) < $signed(bb)) ? 32'd1 : 32'd0;
            AluSltu:  r = (a < bb) ? 32'd1 : 32'd0;
            AluXor:   r = a ^ bb;
            AluSrl:   r = a >> bb[4:0];
            AluSra:   r = (a >> bb[4:0]) | (a[31] ? ~(32'hFFFF_FFFF >> bb[4:0]) : 32'd0);
            AluOr:    r = a | bb;
            AluAnd:   r = a & bb;
            AluPassB: r = bb;
            default:  legal = 1'b0;
         endcase
         case (b.br_op)
            BrNone:  taken = 1'b0;
            BrEq:    taken = b.rs1_data == b.rs2_data;
            BrNe:    taken = b.rs1_data != b.rs2_data;
            BrLt:    taken = $signed(b.rs1_data) < $signed(b.rs2_data);
            BrGe:    taken = !($signed(b.rs1_data) < $signed(b.rs2_data));
            BrLtu:   taken = b.rs1_data < b.rs2_data;
            BrGeu:   taken = !(b.rs1_data < b.rs2_data);
            default: begin taken = 1'b0; legal = 1'b0; end
         endcase
         if (legal) begin
            e.result   = r;
            e.redirect = taken;
         end else begin
            e.illegal = 1'b1;
            e.rd_wen  = 1'b0;
         end
      end
      return e;
   endfunction

   function automatic pipeline_bus_t rand_bus();
      pipeline_bus_t b;
      int            k;
      b          = '0;
      b.pc       = $urandom & 32'hFFFF_FFFC;
      b.rs1_data = $urandom;
      b.rs2_data = ($urandom_range(0, 3) == 0) ? b.rs1_data : $urandom;
      b.imm      = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 63) : $urandom;
      b.rd       = 5'($urandom_range(0, 31));
      b.rd_wen   = 1'($urandom_range(0, 1));
      b.alu_op   = alu_op_e'($urandom_range(0, 11));
      b.op_a_pc  = 1'($urandom_range(0, 1));
      b.op_b_imm = 1'($urandom_range(0, 1));
      b.mul_op   = mul_op_e'($urandom_range(0, 3));
      k = $urandom_range(0, 9);
      if (k == 7) b.br_op = br_op_e'($urandom_range(1, 7));
      else if (k == 8) begin
         if ($urandom_range(0, 1) == 0) b.is_jal = 1'b1;
         else b.is_jalr = 1'b1;
      end else if (k == 9) b.is_mul = 1'b1;
      return b;
   endfunction

   // One clock of stimulus; the model advances at the edge and pushes expected outputs
   task automatic step(input logic v, input pipeline_bus_t b, input logic mr, input logic fl);
      logic rdy, acc;
      exp_t e;
      id_valid  = v;
      id_bus    = b;
      mem_ready = mr;
      flush     = fl;
      @(negedge clk);
      rdy = !mul_active && (!m_valid || mr);
      check("ex_ready", {31'd0, ex_ready}, {31'd0, rdy});
      check("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
      acc = v && rdy && !(m_valid && m_redirect && mr);
      e   = predict(b);
      @(posedge clk);
      if (fl) begin
         m_valid    = 1'b0;
         m_redirect = 1'b0;
         mul_active = 1'b0;
         sb_q.delete();
      end else begin
         if (m_valid && mr) begin
            m_valid    = 1'b0;
            m_redirect = 1'b0;
         end
         if (mul_active) begin
            if (mul_wait > 0) mul_wait--;
            else if (!m_valid) begin
               sb_q.push_back(mul_item);
               m_valid    = 1'b1;
               mul_active = 1'b0;
            end
         end else if (acc) begin
            if (b.is_mul && MulEn) begin
               mul_active = 1'b1;
               mul_wait   = 32;
               mul_item   = e;
            end else begin
               sb_q.push_back(e);
               m_valid    = 1'b1;
               m_redirect = e.redirect;
            end
         end
      end
      #1;
   endtask

   // Monitor: every presented cycle must match the head; pop on transfer
   exp_t mon_e;
   always @(negedge clk) begin
      if (!rst && ex_valid && !flush) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: got result 0x%08h pc 0x%08h expected none",
                     result, pc);
         end else begin
            mon_e = sb_q[0];
            check("result", result, mon_e.result);
            check("store_data", store_data, mon_e.store_data);
            check("pc", pc, mon_e.pc);
            check("rd", {27'd0, rd}, {27'd0, mon_e.rd});
            check("rd_wen", {31'd0, rd_wen}, {31'd0, mon_e.rd_wen});
            check("redirect", {31'd0, redirect}, {31'd0, mon_e.redirect});
            check("illegal", {31'd0, illegal}, {31'd0, mon_e.illegal});
            if (mon_e.redirect) check("redirect_pc", redirect_pc, mon_e.redirect_pc);
            if (mem_ready) void'(sb_q.pop_front());
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   pipeline_bus_t nop, b;

   initial begin
      nop       = '0;
      rst       = 1'b1;
      id_valid  = 1'b0;
      id_bus    = '0;
      flush     = 1'b0;
      mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_valid", {31'd0, ex_valid}, 32'd0);
      check("rst_ready", {31'd0, ex_ready}, 32'd1);
      check("rst_result", result, 32'd0);
      check("rst_redirect", {31'd0, redirect}, 32'd0);
      check("rst_redirect_pc", redirect_pc, 32'd0);
      check("rst_illegal", {31'd0, illegal}, 32'd0);
      check("rst_misc", {pc[7:0], store_data[7:0], 3'd0, rd, 7'd0, rd_wen}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // ADD 5 + 7
      b = nop; b.rs1_data = 32'd5; b.rs2_data = 32'd7; b.rd = 5'd3; b.rd_wen = 1'b1;
      step(1'b1, b, 1'b1, 1'b0);
      step(1'b0, nop, 1'b1, 1'b0);

      // BEQ taken, followed by a wrong-path ADD that must vanish
      b = nop; b.pc = 32'h100; b.rs1_data = 32'd9; b.rs2_data = 32'd9; b.imm = 32'h20;
      b.br_op = BrEq;
      step(1'b1, b, 1'b1, 1'b0);
      b = nop; b.rs1_data = 32'd1; b.rs2_data = 32'd1; b.rd = 5'd4; b.rd_wen = 1'b1;
      step(1'b1, b, 1'b1, 1'b0);
      step(1'b0, nop, 1'b1, 1'b0);

      // JALR pc=0x40 rs1=0x203
      b = nop; b.pc = 32'h40; b.rs1_data = 32'h203; b.is_jalr = 1'b1; b.rd = 5'd1;
      b.rd_wen = 1'b1;
      step(1'b1, b, 1'b1, 1'b0);
      step(1'b0, nop, 1'b1, 1'b0);

      // SUB 3 - 5 held under backpressure with a follower waiting
      b = nop; b.rs1_data = 32'd3; b.rs2_data = 32'd5; b.alu_op = AluSub; b.rd = 5'd2;
      b.rd_wen = 1'b1;
      step(1'b1, b, 1'b1, 1'b0);
      b = nop; b.rs1_data = 32'd8; b.imm = 32'd2; b.op_b_imm = 1'b1; b.alu_op = AluSll;
      b.rd_wen = 1'b1;
      repeat (3) step(1'b1, b, 1'b0, 1'b0);
      step(1'b1, b, 1'b1, 1'b0);
      step(1'b0, nop, 1'b1, 1'b0);

      // MULH -2 x 3, then flush mid-multiply, then MUL 6 x 7
      b = nop; b.is_mul = 1'b1; b.mul_op = MulH; b.rs1_data = 32'hFFFF_FFFE;
      b.rs2_data = 32'd3; b.rd = 5'd5; b.rd_wen = 1'b1;
      step(1'b1, b, 1'b1, 1'b0);
      repeat (36) step(1'b0, nop, 1'b1, 1'b0);
      b.mul_op = MulLo;
      step(1'b1, b, 1'b1, 1'b0);
      repeat (10) step(1'b0, nop, 1'b1, 1'b0);
      step(1'b0, nop, 1'b1, 1'b1);
      repeat (40) step(1'b0, nop, 1'b1, 1'b0);
      b.rs1_data = 32'd6; b.rs2_data = 32'd7;
      step(1'b1, b, 1'b1, 1'b0);
      repeat (36) step(1'b0, nop, 1'b1, 1'b0);

      // Randomized traffic with backpressure and occasional flushes
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 3) != 0, rand_bus(), $urandom_range(0, 3) != 0,
              $urandom_range(0, 31) == 0);
      end
      repeat (40) step(1'b0, nop, 1'b1, 1'b0);
      check("drain_empty", sb_q.size(), 32'd0);
      check("drain_idle", {31'd0, mul_active}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
